parent_rr: RTL and testbench
============================

# parent_rr

Parametrised successor to the single-child parent FSM. It serves N_CHILD children round-robin, and each service runs the same SLEEP → COOK → BOOK → SLEEP sequence. Wakeup requests are latched as pending, so no request is lost while another child is being served. COOK and BOOK phase lengths are programmable by parameter. The block sits in the household-control layer and drives per-child one-hot `food`/`book` strobes plus a completion pulse.

## Interface
Parameters:
- N_CHILD, 4: number of children (requesters); 2..16.
- COOK_CYC, 2: cycles `food` is held per service; ≥1.
- BOOK_CYC, 3: cycles `book` is held per service; ≥1.

Ports:
- clk  in  1  clock.
- resetb  in  1  reset, asynchronous, active-low.
- wakeup  in  N_CHILD  per-child request; a high level is sampled every cycle; no ack needed.
- food  out  N_CHILD  one-hot (or zero): child being fed.
- book  out  N_CHILD  one-hot (or zero): child being taught.
- busy  out  1  high whenever state ≠ SLEEP.
- done  out  1  one-cycle pulse on the last BOOK cycle.
- done_id  out  $clog2(N_CHILD)  index of the child served; valid when done=1, otherwise holds its last value.
- pending  out  N_CHILD  latched outstanding requests (status).

## Operation
- States: SLEEP, COOK, BOOK.
- Registers:
  - `state`
  - `sel`: served index
  - `cnt`: phase counter
  - `last`: round-robin pointer
  - `pending`
  - `food`, `book`, `done`, `done_id`
  - All are registered; no output is combinational from inputs.
- Pending update each cycle: pending_next = (pending & ~clr) | wakeup. `clr` is onehot(sel) on the done cycle, otherwise 0. Set wins over clear for the same bit.
- SLEEP:
  - If pending ≠ 0, choose the winner: the first set bit searching from last+1 upward, wrapping modulo N_CHILD.
  - Then: sel←winner, cnt←0, food←onehot(winner), state←COOK.
  - A wakeup arriving in the same cycle is not eligible; arbitration uses the registered `pending` only.
- COOK:
  - cnt increments each cycle.
  - When cnt==COOK_CYC-1: food←0, book←onehot(sel), cnt←0, state←BOOK.
- BOOK:
  - cnt increments each cycle.
  - When cnt==BOOK_CYC-1: book←0, done←1, done_id←sel, last←sel, clear pending[sel] (subject to set-wins), state←SLEEP.
- SLEEP always lasts at least one cycle between services, because arbitration sees the pending value after the clear.
- Illegal state encoding: go to SLEEP and drive outputs to 0.
- Reset values: state=SLEEP, pending=0, food=0, book=0, done=0, done_id=0, busy=0, cnt=0, sel=0, last=N_CHILD-1 (child 0 has first priority).
- Reset mid-service drops the service immediately. No done pulse is produced, and all pending requests are lost.

## Timing
- Latency from wakeup[i] high (cycle t, idle, no other pending):
  - pending[i]=1 at t+1.
  - food[i]=1 during t+2 .. t+1+COOK_CYC.
  - book[i]=1 for the following BOOK_CYC cycles.
  - done in the last of those cycles.
- Service period: COOK_CYC+BOOK_CYC+1 cycles per child under continuous load.
- food and book are never high in the same cycle. At most one bit of each is set.
- busy=1 from the first COOK cycle through the last BOOK cycle inclusive.
- Continuous wakeup[i] held high: child i is re-served, but only after every other pending child has had a turn.

## Structure
- Package `parent_pkg`:
  - State enum/localparams: SLEEP=2'b00, COOK=2'b01, BOOK=2'b10.
  - Counter width function: $clog2(max(COOK_CYC,BOOK_CYC)+1).
- Sub-module `rr_arb`:
  - Combinational round-robin picker, parametrised by N.
  - Inputs: req[N], last[$clog2(N)].
  - Outputs: any, idx.
- Top level holds the FSM, counter, pending register and output registers.

## Test plan
- Reset, then idle with wakeup=0 for 10 cycles → all outputs 0, busy=0, pending=0.
- Defaults; pulse wakeup[2] for 1 cycle at t → food=4'b0100 in t+2,t+3; book=4'b0100 in t+4..t+6; done=1, done_id=2 at t+6; SLEEP at t+7.
- wakeup=4'b1111 held for 1 cycle from reset → serve order 0,1,2,3. Each done is 6 cycles apart, pending empties after the 4th done, and no overlap of food/book occurs.
- wakeup[1] held high continuously, wakeup[3] pulsed during child 1's COOK → the next service is child 3, then child 1 again (fairness).
- wakeup[0] pulsed on child 0's done cycle → pending[0] stays 1 (set wins), and child 0 is served again after one SLEEP cycle.
- Assert resetb=0 asynchronously mid-BOOK → book, busy and pending go to 0 immediately with no done pulse. After release, last=N_CHILD-1 and child 0 has priority.

Source files
------------

// File: rtl/parent_pkg.sv
// Shared types and helpers for the round-robin parent controller.
package parent_pkg;

  typedef enum logic [1:0] {
    SLEEP = 2'b00,
    COOK  = 2'b01,
    BOOK  = 2'b10
  } state_t;

  // Phase counter width: wide enough for the longer of the two phases.
  function automatic int cnt_width(input int cook_cyc, input int book_cyc);
    int m;
    m = (cook_cyc > book_cyc) ? cook_cyc : book_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    any = |req;
    idx = '0;
    j   = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/parent_rr.sv
// Round-robin parent: serves N_CHILD children through SLEEP -> COOK -> BOOK.
module parent_rr
  import parent_pkg::*;
#(
  parameter int N_CHILD  = 4,
  parameter int COOK_CYC = 2,
  parameter int BOOK_CYC = 3,
  parameter int IW       = $clog2(N_CHILD)
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic [N_CHILD-1:0] wakeup,
  output logic [N_CHILD-1:0] food,
  output logic [N_CHILD-1:0] book,
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      done_id,
  output logic [N_CHILD-1:0] pending
);

  localparam int CW = cnt_width(COOK_CYC, BOOK_CYC);
  localparam logic [CW-1:0] COOK_LAST = CW'(COOK_CYC - 1);
  localparam logic [CW-1:0] BOOK_LAST = CW'(BOOK_CYC - 1);

  state_t             state, state_nx;
  logic [IW-1:0]      sel, sel_nx;
  logic [IW-1:0]      last, last_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [N_CHILD-1:0] pending_nx, clr;
  logic [N_CHILD-1:0] food_nx, book_nx;
  logic               done_nx, busy_nx;
  logic [IW-1:0]      done_id_nx;
  logic               arb_any;
  logic [IW-1:0]      arb_idx;

  rr_arb #(.N(N_CHILD), .IW(IW)) u_arb (
    .req  (pending),
    .last (last),
    .any  (arb_any),
    .idx  (arb_idx)
  );

  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    last_nx    = last;
    cnt_nx     = cnt;
    food_nx    = food;
    book_nx    = book;
    done_nx    = 1'b0;
    done_id_nx = done_id;
    clr        = '0;
    if (done) clr[sel] = 1'b1;
    // A wakeup in the same cycle as the clear keeps the request alive.
    pending_nx = (pending & ~clr) | wakeup;

    case (state)
      SLEEP: begin
        if (arb_any) begin
          sel_nx           = arb_idx;
          cnt_nx           = '0;
          food_nx          = '0;
          food_nx[arb_idx] = 1'b1;
          state_nx         = COOK;
        end
      end
      COOK: begin
        if (cnt == COOK_LAST) begin
          food_nx      = '0;
          book_nx      = '0;
          book_nx[sel] = 1'b1;
          cnt_nx       = '0;
          state_nx     = BOOK;
          if (BOOK_CYC == 1) begin
            done_nx    = 1'b1;
            done_id_nx = sel;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      BOOK: begin
        if (cnt == BOOK_LAST) begin
          book_nx  = '0;
          last_nx  = sel;
          cnt_nx   = '0;
          state_nx = SLEEP;
        end else begin
          cnt_nx = cnt + 1'b1;
          // done is registered, so it is raised on entry to the last BOOK cycle.
          if (cnt_nx == BOOK_LAST) begin
            done_nx    = 1'b1;
            done_id_nx = sel;
          end
        end
      end
      default: begin
        state_nx = SLEEP;
        food_nx  = '0;
        book_nx  = '0;
        cnt_nx   = '0;
      end
    endcase

    busy_nx = (state_nx != SLEEP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= SLEEP;
      sel     <= '0;
      last    <= IW'(N_CHILD - 1);
      cnt     <= '0;
      pending <= '0;
      food    <= '0;
      book    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      last    <= last_nx;
      cnt     <= cnt_nx;
      pending <= pending_nx;
      food    <= food_nx;
      book    <= book_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      done_id <= done_id_nx;
    end
  end

endmodule

// File: tb/tb_parent_rr.sv
// Self-checking bench for parent_rr with default parameters (4 children, 2 cook, 3 book).
module tb_parent_rr;

  logic       clk;
  logic       resetb;
  logic [3:0] wakeup;
  logic [3:0] food;
  logic [3:0] book;
  logic       busy;
  logic       done;
  logic [1:0] done_id;
  logic [3:0] pending;

  int n_chk  = 0;
  int n_fail = 0;

  int         done_ids [8];
  int         done_cyc [8];
  logic [3:0] done_pend[8];
  int         n_done;

  typedef struct {
    logic [3:0] w;
    logic [3:0] food;
    logic [3:0] book;
    logic       done;
    logic [1:0] id;
    logic       busy;
    logic [3:0] pend;
  } vec_t;

  vec_t tv[8];

  parent_rr dut (
    .clk     (clk),
    .resetb  (resetb),
    .wakeup  (wakeup),
    .food    (food),
    .book    (book),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive wakeup for one cycle, then land 1 time unit after the next rising edge.
  task automatic cyc(input logic [3:0] w);
    wakeup = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    wakeup = '0;
    @(posedge clk);
    #1;
    resetb = 1'b1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_food"}, 32'(food), 32'h0);
    check({name, "_book"}, 32'(book), 32'h0);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_done"}, 32'(done), 32'h0);
    check({name, "_pend"}, 32'(pending), 32'h0);
  endtask

  // Run ncyc cycles; wakeup = hold, plus pulse_val in cycle pulse_at. Records done events.
  task automatic watch(input int ncyc, input logic [3:0] hold, input int pulse_at,
                       input logic [3:0] pulse_val);
    n_done = 0;
    for (int k = 0; k < ncyc; k++) begin
      cyc(hold | ((k == pulse_at) ? pulse_val : 4'h0));
      check("excl_food_book", 32'(food & book), 32'h0);
      check("onehot_food", 32'($onehot0(food)), 32'h1);
      check("onehot_book", 32'($onehot0(book)), 32'h1);
      if (done === 1'b1 && n_done < 8) begin
        done_ids[n_done]  = int'(done_id);
        done_cyc[n_done]  = k + 1;
        done_pend[n_done] = pending;
        n_done++;
      end
    end
  endtask

  initial begin
    tv[0] = '{w: 4'b0100, food: 4'b0000, book: 4'b0000, done: 1'b0, id: 2'd0, busy: 1'b0, pend: 4'b0100};
    tv[1] = '{w: 4'b0000, food: 4'b0100, book: 4'b0000, done: 1'b0, id: 2'd0, busy: 1'b1, pend: 4'b0100};
    tv[2] = '{w: 4'b0000, food: 4'b0100, book: 4'b0000, done: 1'b0, id: 2'd0, busy: 1'b1, pend: 4'b0100};
    tv[3] = '{w: 4'b0000, food: 4'b0000, book: 4'b0100, done: 1'b0, id: 2'd0, busy: 1'b1, pend: 4'b0100};
    tv[4] = '{w: 4'b0000, food: 4'b0000, book: 4'b0100, done: 1'b0, id: 2'd0, busy: 1'b1, pend: 4'b0100};
    tv[5] = '{w: 4'b0000, food: 4'b0000, book: 4'b0100, done: 1'b1, id: 2'd2, busy: 1'b1, pend: 4'b0100};
    tv[6] = '{w: 4'b0000, food: 4'b0000, book: 4'b0000, done: 1'b0, id: 2'd2, busy: 1'b0, pend: 4'b0000};
    tv[7] = '{w: 4'b0000, food: 4'b0000, book: 4'b0000, done: 1'b0, id: 2'd2, busy: 1'b0, pend: 4'b0000};

    resetb = 1'b0;
    wakeup = '0;
    @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_done_id", 32'(done_id), 32'h0);
    resetb = 1'b1;

    for (int k = 0; k < 10; k++) begin
      cyc(4'h0);
      check_idle("idle");
    end

    // Single request from child 2; row r drives cycle t+r, checks cycle t+r+1.
    for (int r = 0; r < 8; r++) begin
      cyc(tv[r].w);
      check($sformatf("vec%0d_food", r), 32'(food), 32'(tv[r].food));
      check($sformatf("vec%0d_book", r), 32'(book), 32'(tv[r].book));
      check($sformatf("vec%0d_done", r), 32'(done), 32'(tv[r].done));
      check($sformatf("vec%0d_id", r), 32'(done_id), 32'(tv[r].id));
      check($sformatf("vec%0d_busy", r), 32'(busy), 32'(tv[r].busy));
      check($sformatf("vec%0d_pend", r), 32'(pending), 32'(tv[r].pend));
    end

    // All four request at once: served 0,1,2,3, dones 6 cycles apart.
    do_reset();
    watch(30, 4'h0, 0, 4'b1111);
    check("all_n_done", 32'(n_done), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_done) begin
        check($sformatf("all_id%0d", i), 32'(done_ids[i]), 32'(i));
        check($sformatf("all_cyc%0d", i), 32'(done_cyc[i]), 32'(6 + 6 * i));
        check($sformatf("all_pend%0d", i), 32'(done_pend[i]), 32'((4'hf << i) & 4'hf));
      end
    end
    check("all_final_pend", 32'(pending), 32'h0);
    check("all_final_busy", 32'(busy), 32'h0);

    // Child 1 held high, child 3 pulsed during child 1's COOK: order 1,3,1.
    do_reset();
    watch(20, 4'b0010, 2, 4'b1000);
    check("fair_n_done", 32'(n_done >= 3), 32'd1);
    if (n_done >= 3) begin
      check("fair_id0", 32'(done_ids[0]), 32'd1);
      check("fair_id1", 32'(done_ids[1]), 32'd3);
      check("fair_id2", 32'(done_ids[2]), 32'd1);
      check("fair_cyc1", 32'(done_cyc[1]), 32'd12);
      check("fair_cyc2", 32'(done_cyc[2]), 32'd18);
    end

    // Wakeup on the done cycle: set wins, re-served after one SLEEP cycle.
    do_reset();
    cyc(4'b0001);
    for (int k = 0; k < 5; k++) cyc(4'b0000);
    check("sw_done", 32'(done), 32'h1);
    check("sw_done_id", 32'(done_id), 32'h0);
    cyc(4'b0001);
    check("sw_pend", 32'(pending), 32'b0001);
    check("sw_sleep_busy", 32'(busy), 32'h0);
    check("sw_sleep_food", 32'(food), 32'h0);
    check("sw_sleep_done", 32'(done), 32'h0);
    cyc(4'b0000);
    check("sw_refood", 32'(food), 32'b0001);
    check("sw_rebusy", 32'(busy), 32'h1);

    // Asynchronous reset mid-BOOK drops the service with no done pulse.
    do_reset();
    cyc(4'b0110);
    for (int k = 0; k < 3; k++) cyc(4'b0000);
    check("rst_pre_book", 32'(book), 32'b0010);
    cyc(4'b0000);
    check("rst_mid_book", 32'(book), 32'b0010);
    resetb = 1'b0;
    #1;
    check_idle("rst_async");
    @(posedge clk);
    #1;
    check("rst_hold_done", 32'(done), 32'h0);
    resetb = 1'b1;
    cyc(4'b1111);
    check("rst_after_pend", 32'(pending), 32'b1111);
    cyc(4'b0000);
    check("rst_after_food", 32'(food), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
